axi_burst_addr_gen: RTL and testbench
=====================================

Name: axi_burst_addr_gen

Overview:
Parametrised AXI4 burst address and strobe generator; successor to the fixed 128-bit / 2-bit-length burst logic inside axi_top.
- Accepts one burst command (address, size, length, type) over a valid/ready handshake.
- Emits one beat per accepted handshake: per-beat address, byte strobe and last flag.
- Supports FIXED, INCR and WRAP bursts with lengths up to 2^LEN_W beats.
- Sits between the master command source and the AW/AR + W channel drivers.

Parameters:
ADDR_W, 64, address width in bits
DATA_W, 128, data bus width in bits; power of 2, 8..1024
LEN_W, 8, burst length field width; beats = len+1

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_addr  in  ADDR_W  start address
cmd_size  in  3  bytes per beat = 1<<cmd_size
cmd_burst  in  2  0 FIXED, 1 INCR, 2 WRAP, 3 reserved
cmd_len  in  LEN_W  beats minus one
beat_valid  out  1  beat available
beat_ready  in  1  beat consumed when beat_valid && beat_ready
beat_addr  out  ADDR_W  beat byte address
beat_strb  out  DATA_W/8  active byte lanes
beat_idx  out  LEN_W  beat number, 0-based
beat_last  out  1  final beat of burst
cmd_err  out  1  one-cycle pulse; accepted command was illegal

Behaviour:
- Reset values: cmd_ready=0 while reset is high, then 1 in IDLE. beat_valid=0, beat_addr=0, beat_strb=0, beat_idx=0, beat_last=0, cmd_err=0. State=IDLE.
- FSM states: IDLE, RUN, ERR.
  - IDLE: cmd_ready=1. On accept, latch the command. Go to ERR if illegal, else RUN.
  - RUN: beat_valid=1. Each beat handshake advances address, strobe and index. The handshake on beat_last returns to IDLE.
  - ERR: cmd_err=1 for exactly one cycle, no beats emitted, then IDLE.
- cmd_ready=0 in RUN and ERR. One burst in flight at a time.
- Latency: first beat_valid appears the cycle after command accept. A new command can be accepted the cycle after the last-beat handshake.
- Illegal commands:
  - (1<<cmd_size) > DATA_W/8.
  - cmd_burst==3.
  - WRAP with cmd_len not in {1,3,7,15}.
  - WRAP with cmd_addr not aligned to 1<<cmd_size.
- Let B = 1<<size and N = len+1.
  - FIXED: every beat address = start.
  - INCR: beat0 = start. Beat n = (start & ~(B-1)) + n*B. Arithmetic is modulo 2^ADDR_W.
  - WRAP: total T = N*B; lower bound L = start & ~(T-1). Next address = addr+B, but if it equals L+T it becomes L.
- Strobe:
  - Lanes span from (addr mod DATA_W/8) up to the end of the B-aligned container: ((addr & ~(B-1)) + B - 1) mod DATA_W/8.
  - An unaligned first INCR/FIXED beat therefore gets a partial strobe.
- beat_last = (beat_idx == len). For len=0, the first beat is also the last.
- Backpressure: while beat_valid && !beat_ready, all beat outputs stay stable.
- Reset asserted mid-burst aborts immediately; all outputs return to reset values. No partial state survives.
- cmd_* inputs are ignored outside IDLE.

Optional Feature:
AXI_BURST_4K_CHECK_EN:
- Defined: an INCR burst whose bytes ((start & ~(B-1)) .. (start & ~(B-1)) + N*B - 1) cross a 4 KB boundary is illegal and goes to ERR.
- Undefined: no boundary check; the burst runs and addresses cross the 4 KB boundary.

Decomposition:
- Package axi_burst_pkg:
  - burst_t enum: FIXED=2'd0, INCR=2'd1, WRAP=2'd2, RSVD=2'd3.
  - state_t enum: IDLE, RUN, ERR.
  - Constant AXI_4K=4096.
  - Function size_bytes(size).
- Sub-module axi_strb_gen: combinational, parameters ADDR_W and DATA_W; inputs addr and size; output strb. Instantiated once.

Test Plan:
- INCR, addr 0x0000_1234_5678_ABCD, size 3, len 3, beat_ready=1:
  - Addresses ...ABCD, ...ABD0, ...ABD8, ...ABE0.
  - Strobes 0xE000, 0x00FF, 0xFF00, 0x00FF.
  - beat_last only on the 4th beat; beat_valid first high the cycle after accept.
- WRAP, addr 0x1038, size 3, len 3: addresses 0x1038, 0x1020, 0x1028, 0x1030; beat_last on 0x1030.
- FIXED, addr 0x2004, size 2, len 2: three beats, all at 0x2004 with strb 0x00F0; beat_idx 0, 1, 2.
- Illegal commands: size 5 on 128-bit bus, and WRAP with len 2. Each gives cmd_err high exactly one cycle, beat_valid never asserts, and cmd_ready returns to 1 after two cycles.
- INCR, addr 0x0FF8, size 3, len 3:
  - With AXI_BURST_4K_CHECK_EN: cmd_err pulse, no beats.
  - Without: beats at 0x0FF8, 0x1000, 0x1008, 0x1010.
- Backpressure and reset:
  - Hold beat_ready=0 for 5 cycles at beat 1: outputs stay stable.
  - Assert reset during beat 2: beat_valid=0 immediately.
  - After reset release: cmd_ready=1 and a new burst starts at beat_idx 0.

Source files
------------

// File: rtl/axi_burst_addr_gen_pkg.sv
//------------------------------------------------------------------------------
// axi_burst_pkg : shared types and helpers for axi_burst_addr_gen  (rev 1.0)
//------------------------------------------------------------------------------
`default_nettype none

package axi_burst_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2,
    RSVD  = 2'd3
  } burst_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam int AXI_4K    = 4096;
  localparam int AXI_4K_SH = $clog2(AXI_4K);

  function automatic logic [7:0] size_bytes(input logic [2:0] size);
    return 8'd1 << size;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_burst_addr_gen_if.sv
//------------------------------------------------------------------------------
// axi_burst_addr_gen_if : command and beat handshake bundle  (rev 1.0)
//------------------------------------------------------------------------------
`default_nettype none

interface axi_burst_addr_gen_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 128,
  parameter int LEN_W  = 8
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [2:0]          cmd_size;
  logic [1:0]          cmd_burst;
  logic [LEN_W-1:0]    cmd_len;
  logic                beat_valid;
  logic                beat_ready;
  logic [ADDR_W-1:0]   beat_addr;
  logic [DATA_W/8-1:0] beat_strb;
  logic [LEN_W-1:0]    beat_idx;
  logic                beat_last;
  logic                cmd_err;

  modport master (
    output cmd_valid, cmd_addr, cmd_size, cmd_burst, cmd_len, beat_ready,
    input  cmd_ready, beat_valid, beat_addr, beat_strb, beat_idx, beat_last, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_size, cmd_burst, cmd_len, beat_ready,
    output cmd_ready, beat_valid, beat_addr, beat_strb, beat_idx, beat_last, cmd_err
  );

endinterface

`default_nettype wire

// File: rtl/axi_burst_addr_gen_strb.sv
//------------------------------------------------------------------------------
// axi_strb_gen : byte-lane strobe from beat address and size  (rev 1.0)
//------------------------------------------------------------------------------
`default_nettype none

module axi_strb_gen #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 128
) (
  input  logic [ADDR_W-1:0]   addr,
  input  logic [2:0]          size,
  output logic [DATA_W/8-1:0] strb
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = (NB > 1) ? $clog2(NB) : 1;

  generate
    if (NB == 1) begin : g_single
      logic unused_in;
      assign unused_in = ^{addr, size};
      assign strb      = 1'b1;
    end else begin : g_multi
      localparam logic [OFF_W:0] ONE = 1;
      logic [OFF_W:0] lo;
      logic [OFF_W:0] hi;
      logic [OFF_W:0] bsz;
      logic           unused_hi;

      assign unused_hi = ^addr[ADDR_W-1:OFF_W];

      // Lanes run from the byte offset to the end of the size-aligned container.
      always_comb begin
        bsz = ONE << size;
        lo  = {1'b0, addr[OFF_W-1:0]};
        hi  = (lo & ~(bsz - ONE)) + bsz - ONE;
        for (int i = 0; i < NB; i++) begin
          strb[i] = ((OFF_W+1)'(i) >= lo) && ((OFF_W+1)'(i) <= hi);
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
//------------------------------------------------------------------------------
// axi_burst_addr_gen : AXI4 FIXED/INCR/WRAP beat address + strobe generator (rev 1.0)
// Optional macro AXI_BURST_4K_CHECK_EN rejects INCR bursts crossing a 4 KB page.
//------------------------------------------------------------------------------
`default_nettype none

module axi_burst_addr_gen
  import axi_burst_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 128,
  parameter int LEN_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  axi_burst_addr_gen_if.slave  bus
);

  localparam logic [ADDR_W-1:0] A_ONE = 1;
  localparam logic [LEN_W-1:0]  L_ONE = 1;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr, wrap_lo, wrap_hi, addr_nxt, addr_inc, b;
  logic [ADDR_W-1:0]   cmd_b, cmd_total;
  logic [2:0]          size;
  burst_t              burst;
  logic [LEN_W-1:0]    len, idx;
  logic                accept, illegal, cross_4k, beat_fire, last;
  logic [DATA_W/8-1:0] strb_raw;

  assign accept    = (state == IDLE) && bus.cmd_valid;
  assign beat_fire = (state == RUN) && bus.beat_ready;
  assign last      = (idx == len);
  assign cmd_b     = ADDR_W'(size_bytes(bus.cmd_size));
  assign cmd_total = ADDR_W'({1'b0, bus.cmd_len} + {{LEN_W{1'b0}}, 1'b1}) << bus.cmd_size;

`ifdef AXI_BURST_4K_CHECK_EN
  logic [ADDR_W-1:0] cmd_base, cmd_end;
  assign cmd_base = bus.cmd_addr & ~(cmd_b - A_ONE);
  assign cmd_end  = cmd_base + cmd_total - A_ONE;
  assign cross_4k = (bus.cmd_burst == INCR) &&
                    ((cmd_base >> AXI_4K_SH) != (cmd_end >> AXI_4K_SH));
`else
  assign cross_4k = 1'b0;
`endif

  always_comb begin
    illegal = cross_4k;
    if (32'(size_bytes(bus.cmd_size)) > 32'(DATA_W / 8)) illegal = 1'b1;
    if (bus.cmd_burst == RSVD) illegal = 1'b1;
    if (bus.cmd_burst == WRAP) begin
      if (!(bus.cmd_len == LEN_W'(1) || bus.cmd_len == LEN_W'(3) ||
            bus.cmd_len == LEN_W'(7) || bus.cmd_len == LEN_W'(15))) illegal = 1'b1;
      if ((bus.cmd_addr & (cmd_b - A_ONE)) != '0) illegal = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = illegal ? ERR : RUN;
      RUN:     if (beat_fire && last) state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // INCR realigns after the first beat; WRAP folds back to the window base.
  always_comb begin
    b        = ADDR_W'(size_bytes(size));
    addr_inc = addr + b;
    case (burst)
      FIXED:   addr_nxt = addr;
      WRAP:    addr_nxt = (addr_inc == wrap_hi) ? wrap_lo : addr_inc;
      default: addr_nxt = (addr & ~(b - A_ONE)) + b;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr    <= '0;
      wrap_lo <= '0;
      wrap_hi <= '0;
      size    <= '0;
      burst   <= FIXED;
      len     <= '0;
      idx     <= '0;
    end else if (accept) begin
      addr    <= bus.cmd_addr;
      size    <= bus.cmd_size;
      burst   <= burst_t'(bus.cmd_burst);
      len     <= bus.cmd_len;
      idx     <= '0;
      wrap_lo <= bus.cmd_addr & ~(cmd_total - A_ONE);
      wrap_hi <= (bus.cmd_addr & ~(cmd_total - A_ONE)) + cmd_total;
    end else if (beat_fire && !last) begin
      addr <= addr_nxt;
      idx  <= idx + L_ONE;
    end
  end

  axi_strb_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_strb (
    .addr (addr),
    .size (size),
    .strb (strb_raw)
  );

  assign bus.cmd_ready  = (state == IDLE) && !reset;
  assign bus.beat_valid = (state == RUN);
  assign bus.beat_addr  = addr;
  assign bus.beat_idx   = idx;
  assign bus.beat_last  = (state == RUN) && last;
  assign bus.beat_strb  = (state == RUN) ? strb_raw : '0;
  assign bus.cmd_err    = (state == ERR);

endmodule

`default_nettype wire

// File: tb/tb_axi_burst_addr_gen.sv
//------------------------------------------------------------------------------
// tb_axi_burst_addr_gen : scoreboard bench for axi_burst_addr_gen  (rev 1.0)
//------------------------------------------------------------------------------
`default_nettype none

module tb_axi_burst_addr_gen;

  typedef struct packed {
    logic [63:0] addr;
    logic [15:0] strb;
    logic [7:0]  idx;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   err_pending = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  axi_burst_addr_gen_if #(.ADDR_W(64), .DATA_W(128), .LEN_W(8)) bus ();

  axi_burst_addr_gen #(.ADDR_W(64), .DATA_W(128), .LEN_W(8)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_beat(input logic [63:0] a, input logic [15:0] s, input logic [7:0] i, input logic l);
    beat_t e;
    e.addr = a; e.strb = s; e.idx = i; e.last = l;
    exp_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every beat handshake and every error pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.beat_valid && bus.beat_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", bus.beat_addr, 64'hDEAD);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_addr", bus.beat_addr, e.addr);
          check("beat_strb", 64'(bus.beat_strb), 64'(e.strb));
          check("beat_idx",  64'(bus.beat_idx),  64'(e.idx));
          check("beat_last", 64'(bus.beat_last), 64'(e.last));
        end
      end
      if (bus.cmd_err) begin
        check("cmd_err_expected", 64'(err_pending > 0), 64'd1);
        if (err_pending > 0) err_pending--;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.cmd_ready) check("cmd_ready_timeout", 64'(bus.cmd_ready), 64'd1);
  endtask

  task automatic send_cmd(input logic [63:0] a, input logic [2:0] s, input logic [1:0] bt, input logic [7:0] l);
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_size  = s;
    bus.cmd_burst = bt;
    bus.cmd_len   = l;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_size = '0;
    bus.cmd_burst = '0;   bus.cmd_len  = '0; bus.beat_ready = 1'b1;
    #1;
    check("rst_cmd_ready",  64'(bus.cmd_ready),  64'd0);
    check("rst_beat_valid", 64'(bus.beat_valid), 64'd0);
    check("rst_beat_addr",  bus.beat_addr,       64'd0);
    check("rst_beat_strb",  64'(bus.beat_strb),  64'd0);
    check("rst_beat_idx",   64'(bus.beat_idx),   64'd0);
    check("rst_beat_last",  64'(bus.beat_last),  64'd0);
    check("rst_cmd_err",    64'(bus.cmd_err),    64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    // INCR, unaligned start
    exp_beat(64'h0000_1234_5678_ABCD, 16'hE000, 8'd0, 1'b0);
    exp_beat(64'h0000_1234_5678_ABD0, 16'h00FF, 8'd1, 1'b0);
    exp_beat(64'h0000_1234_5678_ABD8, 16'hFF00, 8'd2, 1'b0);
    exp_beat(64'h0000_1234_5678_ABE0, 16'h00FF, 8'd3, 1'b1);
    check("pre_accept_valid", 64'(bus.beat_valid), 64'd0);
    send_cmd(64'h0000_1234_5678_ABCD, 3'd3, 2'd1, 8'd3);
    check("first_beat_latency", 64'(bus.beat_valid), 64'd1);
    check("busy_cmd_ready",     64'(bus.cmd_ready),  64'd0);

    // WRAP
    exp_beat(64'h1038, 16'hFF00, 8'd0, 1'b0);
    exp_beat(64'h1020, 16'h00FF, 8'd1, 1'b0);
    exp_beat(64'h1028, 16'hFF00, 8'd2, 1'b0);
    exp_beat(64'h1030, 16'h00FF, 8'd3, 1'b1);
    send_cmd(64'h1038, 3'd3, 2'd2, 8'd3);

    // FIXED
    exp_beat(64'h2004, 16'h00F0, 8'd0, 1'b0);
    exp_beat(64'h2004, 16'h00F0, 8'd1, 1'b0);
    exp_beat(64'h2004, 16'h00F0, 8'd2, 1'b1);
    send_cmd(64'h2004, 3'd2, 2'd0, 8'd2);

    // single-beat INCR, full-width size
    exp_beat(64'h40, 16'hFFFF, 8'd0, 1'b1);
    send_cmd(64'h40, 3'd4, 2'd1, 8'd0);

    // Illegal commands: oversize beat, bad WRAP length
    for (int k = 0; k < 2; k++) begin
      err_pending++;
      if (k == 0) send_cmd(64'h100, 3'd5, 2'd1, 8'd0);
      else        send_cmd(64'h100, 3'd3, 2'd2, 8'd2);
      check("err_pulse",     64'(bus.cmd_err),    64'd1);
      check("err_ready_low", 64'(bus.cmd_ready),  64'd0);
      check("err_no_beat",   64'(bus.beat_valid), 64'd0);
      @(posedge clk); #1;
      check("err_cleared",   64'(bus.cmd_err),    64'd0);
      check("err_ready_back",64'(bus.cmd_ready),  64'd1);
      check("err_no_beat2",  64'(bus.beat_valid), 64'd0);
    end

    // INCR across a 4 KB boundary
`ifdef AXI_BURST_4K_CHECK_EN
    err_pending++;
`else
    exp_beat(64'h0FF8, 16'hFF00, 8'd0, 1'b0);
    exp_beat(64'h1000, 16'h00FF, 8'd1, 1'b0);
    exp_beat(64'h1008, 16'hFF00, 8'd2, 1'b0);
    exp_beat(64'h1010, 16'h00FF, 8'd3, 1'b1);
`endif
    send_cmd(64'h0FF8, 3'd3, 2'd1, 8'd3);

    // Backpressure at beat 1, then reset during beat 2
    exp_beat(64'h3000, 16'hFFFF, 8'd0, 1'b0);
    exp_beat(64'h3010, 16'hFFFF, 8'd1, 1'b0);
    send_cmd(64'h3000, 3'd4, 2'd1, 8'd3);
    @(posedge clk); #1;
    bus.beat_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 64'(bus.beat_valid), 64'd1);
      check("bp_addr",  bus.beat_addr,       64'h3010);
      check("bp_strb",  64'(bus.beat_strb),  64'hFFFF);
      check("bp_idx",   64'(bus.beat_idx),   64'd1);
      check("bp_last",  64'(bus.beat_last),  64'd0);
      @(posedge clk); #1;
    end
    bus.beat_ready = 1'b1;
    @(posedge clk); #1;
    check("beat2_valid", 64'(bus.beat_valid), 64'd1);
    check("beat2_idx",   64'(bus.beat_idx),   64'd2);
    rst = 1'b1;
    #1;
    check("abort_valid",  64'(bus.beat_valid), 64'd0);
    check("abort_addr",   bus.beat_addr,       64'd0);
    check("abort_strb",   64'(bus.beat_strb),  64'd0);
    check("abort_ready",  64'(bus.cmd_ready),  64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(bus.cmd_ready),  64'd1);
    check("post_rst_valid", 64'(bus.beat_valid), 64'd0);

    exp_beat(64'h50, 16'h0001, 8'd0, 1'b0);
    exp_beat(64'h51, 16'h0002, 8'd1, 1'b1);
    send_cmd(64'h50, 3'd0, 2'd1, 8'd1);

    wait_ready();
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("errors_drained",     64'(err_pending),  64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
